// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel scan controller and its address generator.
package sobel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FETCH,
        WAIT_RES,
        WR_X,
        WR_Y,
        WR_C,
        DONE
    } state_t;

    localparam logic [1:0] CSEL_X = 2'b01;
    localparam logic [1:0] CSEL_Y = 2'b10;
    localparam logic [1:0] CSEL_C = 2'b11;

    localparam int unsigned IMG_W_DEF = 256;
    localparam int unsigned IMG_H_DEF = 256;
    localparam int unsigned PAD_W_DEF = 258;

endpackage

// File: rtl/sobel_addr_gen.sv
// Scan position registers: source row base / column, result row / column and pixel counter.
module sobel_addr_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W   = IMG_W_DEF,
    parameter int unsigned IMG_H   = IMG_H_DEF,
    parameter int unsigned PAD_W   = PAD_W_DEF,
    parameter int unsigned IADDR_W = 17,
    parameter int unsigned CADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_col_adv,
    input  logic               i_pix_done,
    input  logic [1:0]         i_row_sel,
    output logic [IADDR_W-1:0] o_iaddr,
    output logic [CADDR_W-1:0] o_caddr,
    output logic               o_last_col,
    output logic               o_last_row
);

    localparam logic [IADDR_W-1:0] ROW1_OFF = IADDR_W'(PAD_W);
    localparam logic [IADDR_W-1:0] ROW2_OFF = IADDR_W'(2 * PAD_W);
    localparam logic [IADDR_W-1:0] ONE_I    = IADDR_W'(1);
    localparam logic [CADDR_W-1:0] ONE_C    = CADDR_W'(1);
    localparam logic [CADDR_W-1:0] LAST_C   = CADDR_W'(IMG_W - 1);
    localparam logic [CADDR_W-1:0] LAST_R   = CADDR_W'(IMG_H - 1);
    localparam logic [CADDR_W-1:0] LAST_PIX = CADDR_W'(IMG_W * IMG_H - 1);

    logic [IADDR_W-1:0] r_rowbase;
    logic [IADDR_W-1:0] r_c_src;
    logic [CADDR_W-1:0] r_c;
    logic [CADDR_W-1:0] r_r;
    logic [CADDR_W-1:0] r_pix;
    logic [IADDR_W-1:0] w_row_off;

    always_comb begin
        w_row_off = '0;
        case (i_row_sel)
            2'd1:    w_row_off = ROW1_OFF;
            2'd2:    w_row_off = ROW2_OFF;
            default: w_row_off = '0;
        endcase
    end

    assign o_iaddr    = r_rowbase + r_c_src + w_row_off;
    assign o_caddr    = r_pix;
    assign o_last_col = (r_c == LAST_C);
    assign o_last_row = (r_r == LAST_R);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rowbase <= '0;
            r_c_src   <= '0;
            r_c       <= '0;
            r_r       <= '0;
            r_pix     <= '0;
        end else if (i_start) begin
            r_rowbase <= '0;
            r_c_src   <= '0;
            r_c       <= '0;
            r_r       <= '0;
            r_pix     <= '0;
        end else begin
            if (i_col_adv) begin
                r_c_src <= r_c_src + ONE_I;
            end
            if (i_pix_done) begin
                r_pix <= (r_pix == LAST_PIX) ? '0 : r_pix + ONE_C;
                // On the final pixel only the counter moves; row state is left as-is for DONE.
                if (!o_last_col) begin
                    r_c <= r_c + ONE_C;
                end else if (!o_last_row) begin
                    r_c       <= '0;
                    r_r       <= r_r + ONE_C;
                    r_c_src   <= '0;
                    r_rowbase <= r_rowbase + ROW1_OFF;
                end
            end
        end
    end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Raster-scan sequencer: feeds padded columns to the Sobel datapath and writes X/Y/combine results.
module sobel_scan_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W   = IMG_W_DEF,
    parameter int unsigned IMG_H   = IMG_H_DEF,
    parameter int unsigned PAD_W   = PAD_W_DEF,
    parameter int unsigned IADDR_W = 17,
    parameter int unsigned CADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    output logic               busy,
    output logic [IADDR_W-1:0] iaddr,
    input  logic [7:0]         idata,
    output logic               col_shift,
    output logic [23:0]        col_data,
    output logic               win_valid,
    input  logic               res_valid,
    input  logic [7:0]         res_x,
    input  logic [7:0]         res_y,
    input  logic [7:0]         res_c,
    output logic               cwr,
    output logic [1:0]         csel,
    output logic [CADDR_W-1:0] caddr_wr,
    output logic [7:0]         cdata_wr,
    output logic               crd,
    output logic [CADDR_W-1:0] caddr_rd,
    output logic               proto_err
);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_k;
    logic [1:0]  r_need;
    logic [23:0] r_col;
    logic        r_col_shift;
    logic        r_win_valid;
    logic [7:0]  r_res_x;
    logic [7:0]  r_res_y;
    logic [7:0]  r_res_c;
    logic        r_busy;
    logic        r_proto_err;

    logic        w_start;
    logic        w_col_adv;
    logic        w_pix_done;
    logic [1:0]  w_row_sel;
    logic        w_last_col;
    logic        w_last_row;

    sobel_addr_gen #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .PAD_W   (PAD_W),
        .IADDR_W (IADDR_W),
        .CADDR_W (CADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (reset),
        .i_start    (w_start),
        .i_col_adv  (w_col_adv),
        .i_pix_done (w_pix_done),
        .i_row_sel  (w_row_sel),
        .o_iaddr    (iaddr),
        .o_caddr    (caddr_wr),
        .o_last_col (w_last_col),
        .o_last_row (w_last_row)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_col_adv    = 1'b0;
        w_pix_done   = 1'b0;
        w_row_sel    = 2'd0;
        cwr          = 1'b0;
        csel         = 2'b00;
        cdata_wr     = '0;
        case (r_state)
            IDLE: begin
                if (ready) w_state_next = START;
            end
            START: begin
                w_start      = 1'b1;
                w_state_next = FETCH;
            end
            FETCH: begin
                if (r_k != 2'd3) w_row_sel = r_k;
                if (r_k == 2'd3) begin
                    w_col_adv = 1'b1;
                    if (r_need == 2'd1) w_state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid) w_state_next = WR_X;
            end
            WR_X: begin
                cwr          = 1'b1;
                csel         = CSEL_X;
                cdata_wr     = r_res_x;
                w_state_next = WR_Y;
            end
            WR_Y: begin
                cwr          = 1'b1;
                csel         = CSEL_Y;
                cdata_wr     = r_res_y;
                w_state_next = WR_C;
            end
            WR_C: begin
                cwr          = 1'b1;
                csel         = CSEL_C;
                cdata_wr     = r_res_c;
                w_pix_done   = 1'b1;
                w_state_next = (w_last_col && w_last_row) ? DONE : FETCH;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // col_shift trails the third capture by a cycle so col_data is complete when it is seen;
    // win_valid follows the final shift of a window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k         <= '0;
            r_need      <= '0;
            r_col       <= '0;
            r_col_shift <= 1'b0;
            r_win_valid <= 1'b0;
            r_res_x     <= '0;
            r_res_y     <= '0;
            r_res_c     <= '0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_busy      <= (w_state_next != IDLE);
            r_col_shift <= (r_state == FETCH) && (r_k == 2'd3);
            r_win_valid <= r_col_shift && (r_state == WAIT_RES);
            if (res_valid) begin
                if (r_state == WAIT_RES) begin
                    r_res_x <= res_x;
                    r_res_y <= res_y;
                    r_res_c <= res_c;
                end else begin
                    r_proto_err <= 1'b1;
                end
            end
            case (r_state)
                START: begin
                    r_k    <= '0;
                    r_need <= 2'd3;
                end
                FETCH: begin
                    r_k <= r_k + 2'd1;
                    case (r_k)
                        2'd1: r_col[23:16] <= idata;
                        2'd2: r_col[15:8]  <= idata;
                        2'd3: begin
                            r_col[7:0] <= idata;
                            r_need     <= r_need - 2'd1;
                        end
                        default: ;
                    endcase
                end
                WR_C: begin
                    r_k    <= '0;
                    r_need <= w_last_col ? 2'd3 : 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign col_shift = r_col_shift;
    assign col_data  = r_col;
    assign win_valid = r_win_valid;
    assign proto_err = r_proto_err;
    assign crd       = 1'b0;
    assign caddr_rd  = '0;

endmodule
